// File: rtl/bcd_counter_bank.sv
// bcd_counter_bank
// A bank of DIGITS BCD decades that is incremented by a per-decade mask.
// Each increment is applied as a ripple sweep that handles one decade per
// clock, lowest decade first. A separate refresh strobe copies the live count
// into a display register. The copy is deferred while a sweep is running, so
// the display never shows a half-carried value.
//
// Ports
//   clk      : system clock, all state changes on the rising edge
//   reset    : synchronous, active-low reset
//   inc_clk  : one-cycle increment strobe, ignored while busy
//   ref_clk  : one-cycle display refresh strobe
//   trigger  : per-decade increment mask, sampled with inc_clk
//   count    : live BCD count, decade i at [4i+3:4i]
//   display  : BCD snapshot of count, changed only by a refresh
//   busy     : high while a sweep or a deferred refresh is in progress
//   overflow : sticky, set on a carry out of the top decade

module bcd_counter_bank #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_clk,
  input  logic                  ref_clk,
  input  logic [DIGITS-1:0]     trigger,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic                  busy,
  output logic                  overflow
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    REFRESH
  } state_e;

  state_e               state_q, state_d;
  logic [4*DIGITS-1:0]  count_q, count_d;
  logic [4*DIGITS-1:0]  display_q, display_d;
  logic [DIGITS-1:0]    mask_q, mask_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic                 pending_q, pending_d;
  logic                 overflow_q, overflow_d;

  logic [3:0]           curDigit;
  logic [3:0]           sum;
  logic                 sumWraps;
  logic [3:0]           newDigit;

  // Decade arithmetic for the decade selected by the sweep index.
  // The largest possible sum is 9+1+1 = 11, so a 4-bit sum cannot overflow.
  always_comb begin
    curDigit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == i[IDX_W-1:0]) curDigit = count_q[4*i +: 4];
    end
    sum      = curDigit + {3'b000, mask_q[idx_q]} + {3'b000, carry_q};
    sumWraps = (sum >= 4'd10);
    newDigit = sumWraps ? (sum - 4'd10) : sum;
  end

  // Next-state logic for the IDLE / SWEEP / REFRESH controller.
  // A refresh strobe that arrives on the last sweep cycle is merged with the
  // pending flag so that it is not lost when the sweep ends.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    display_d  = display_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (ref_clk) display_d = count_q;
        if (inc_clk) begin
          mask_d  = trigger;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = SWEEP;
        end
      end

      SWEEP: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == i[IDX_W-1:0]) count_d[4*i +: 4] = newDigit;
        end
        carry_d = sumWraps;
        if (ref_clk) pending_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          if (sumWraps) overflow_d = 1'b1;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = (pending_q || ref_clk) ? REFRESH : IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      REFRESH: begin
        display_d = count_q;
        pending_d = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset clears everything, which aborts any sweep or
  // refresh in progress and discards any strobes sampled in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      display_q  <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      display_q  <= display_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign display  = display_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: doc/bcd_counter_bank.md
BCD_COUNTER_BANK -- requirements
Module: bcd_counter_bank

Interface
REQ-001 SHALL have parameter DIGITS, default 6, giving the number of BCD decades (valid range 1..8).
REQ-002 SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: one clock, reset synchronous and active-low (reset=0 sampled at a clk edge resets the block).
REQ-004 SHALL have port inc_clk, input, 1: one-cycle increment strobe from the input trigger stage.
REQ-005 SHALL have port ref_clk, input, 1: one-cycle display-refresh strobe from the input trigger stage.
REQ-006 SHALL have port trigger, input, DIGITS: per-decade increment mask, sampled only when inc_clk=1.
REQ-007 SHALL have port count, output, 4*DIGITS: live BCD count; decade i occupies bits [4i+3:4i].
REQ-008 SHALL have port display, output, 4*DIGITS: BCD snapshot of count, updated only by refresh.
REQ-009 SHALL have port busy, output, 1: high while an add sweep is in progress.
REQ-010 SHALL have port overflow, output, 1: sticky flag, set on carry out of the top decade.

Function
REQ-011 SHALL implement an FSM with states IDLE, SWEEP, REFRESH.
REQ-012 IDLE: on inc_clk=1, latch trigger into an internal mask, clear carry, set decade index to 0, enter SWEEP.
REQ-013 SWEEP: per cycle, process exactly one decade, index k: sum = digit[k] + mask[k] + carry.
REQ-014 SWEEP: if sum >= 10, digit[k] <= sum-10 and carry <= 1; else digit[k] <= sum and carry <= 0.
REQ-015 SWEEP: maximum sum is 11 (9+1+1); 4-bit digit plus 1-bit carry SHALL suffice, no other width.
REQ-016 SWEEP: at k = DIGITS-1, a carry out SHALL wrap that decade (modular result above) and set overflow.
REQ-017 SWEEP: after k = DIGITS-1, go to REFRESH if a refresh is pending, else to IDLE; sweep lasts exactly DIGITS cycles.
REQ-018 busy SHALL be 1 exactly in SWEEP and REFRESH.
REQ-019 inc_clk=1 while busy=1 SHALL be ignored (no mask latch, no count change).
REQ-020 ref_clk=1 in IDLE SHALL load display from count on the next edge, with no state change.
REQ-021 ref_clk=1 during SWEEP SHALL set an internal pending flag; no display update mid-sweep.
REQ-022 REFRESH: load display from count (final post-sweep value), clear pending, return to IDLE; one cycle.
REQ-023 ref_clk=1 in REFRESH SHALL be absorbed by the refresh in progress.
REQ-024 inc_clk=1 and ref_clk=1 together in IDLE: display gets the pre-increment count, sweep starts normally.
REQ-025 count SHALL reflect each decade's update on the edge it is processed; display never shows a partial sweep.
REQ-026 mask all-zero with inc_clk=1 SHALL still run a full DIGITS-cycle sweep leaving count unchanged.
REQ-027 overflow SHALL clear only on reset.
REQ-028 Decade values SHALL remain in 0..9 at all times.

Reset
REQ-029 On reset=0: count=0, display=0, overflow=0, busy=0, mask=0, carry=0, pending=0, index=0, state IDLE.
REQ-030 Reset asserted mid-sweep or in REFRESH SHALL abort the operation; no partial result survives.
REQ-031 Strobes sampled in the reset cycle SHALL be ignored.

Verification
REQ-032 Reset, inc_clk with trigger=000001, ref_clk 8 cycles later -> count=display=000001, busy high 6 cycles.
REQ-033 count=000009, trigger=000001 -> count=000010 after 6 cycles; count=099999, trigger=000001 -> 100000.
REQ-034 count=999999, trigger=000001 -> count=000000, overflow=1, stays 1 after further increments until reset.
REQ-035 trigger=000011 at count=000099 -> count=000110; trigger=111111 at 000000 -> 111111.
REQ-036 ref_clk 2 cycles after inc_clk (mid-sweep) -> display unchanged until REFRESH, then equals final count; second inc_clk during sweep ignored.
REQ-037 reset=0 during third SWEEP cycle -> next cycle all outputs 0, state IDLE; following inc_clk counts from 000000.
